store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the CPU memory-access stage and the data memory (`d_mem`).
- Stores are queued in a small FIFO and retired into `d_mem` one per cycle whenever the memory port is not needed by a load.
- Loads bypass the queue and are serviced immediately, with store-to-load forwarding from the youngest matching buffered entry.
- Frees the CPU from waiting on store completion; stalls the CPU only when the buffer is full.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2).
- PTR_W, 2, log2(DEPTH), width of the head/tail pointers.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  32  word address of the load/store, passed unchanged to `d_mem`.
- cpu_wdata  in  32  store data.
- cpu_we  in  1  store request.
- cpu_re  in  1  load request.
- cpu_rdata  out  32  load result.
- stall  out  1  store not accepted this cycle; the CPU must hold its request.
- empty  out  1  no buffered stores.
- count  out  PTR_W+1  number of valid entries.
- mem_address  out  32  to `d_mem` address.
- mem_writeData  out  32  to `d_mem` writeData.
- mem_memWrite  out  1  to `d_mem` memWrite.
- mem_memRead  out  1  to `d_mem` memRead.
- mem_readData  in  32  from `d_mem` readData (combinational; Z when memRead=0).

Behaviour:
- Reset (rst_n low, asynchronous):
  - head, tail and count are set to 0; all entry valid bits are cleared.
  - Pending stores are discarded.
  - While rst_n is low: mem_memWrite=0, mem_memRead=0, stall=0, empty=1, count=0.
- Port arbitration (combinational, every cycle):
  - cpu_re=1: load owns the port.
    - mem_memRead=1, mem_address=cpu_addr, mem_memWrite=0.
    - No drain this cycle.
  - cpu_re=0 and count>0: drain the head entry.
    - mem_address=head.addr, mem_writeData=head.data, mem_memWrite=1.
    - `d_mem` writes the entry at the next posedge; head and count update on the same edge.
  - Otherwise: mem_memRead=0, mem_memWrite=0, mem_address=0, mem_writeData=0.
- Load data path (combinational, zero-cycle latency):
  - If any valid entry has addr==cpu_addr, cpu_rdata = data of the youngest matching entry (closest to tail).
  - Otherwise cpu_rdata = mem_readData.
  - cpu_rdata=0 when cpu_re=0; no Z ever leaves the block.
- Store acceptance:
  - A store is accepted when cpu_we=1 and (count<DEPTH, or a drain occurs this cycle).
  - On acceptance: the entry is written at tail on the posedge and tail increments (wraps at DEPTH).
  - stall = cpu_we & (count==DEPTH) & ~drain, combinational. A stalled store is not enqueued.
- Count update at posedge: count <= count + push − pop.
  - Push and pop in the same cycle leave count unchanged.
  - The pointers wrap modulo DEPTH.
- Simultaneous cpu_we and cpu_re:
  - The load is served (forwarding considers only entries valid before this edge).
  - The store is enqueued if space exists; if full, stall=1, since no drain occurs while a load holds the port.
- Ordering:
  - Stores retire to `d_mem` strictly in FIFO order.
  - Duplicate addresses are not coalesced.
- Status outputs: empty = (count==0); count is a registered value.
- Reset mid-drain: the asynchronous reset deasserts mem_memWrite immediately; that entry is lost and no partial write occurs.
- Software drain barrier: the CPU observes empty=1 before any operation requiring memory coherence.

Test Plan:
- Reset with cpu_we=1 asserted → count=0, empty=1, mem_memWrite=0, stall=0; after release, the first store is accepted.
- Store (addr 5, data 0xDEADBEEF), then idle → count=1 after edge 1; mem_memWrite=1 with mem_address=5 in cycle 2; `d_mem`[5]=0xDEADBEEF after edge 2; empty=1.
- Stores to addr 3 with data 0x11 then 0x22 while cpu_re=1 holds the port, then load addr 3 → cpu_rdata=0x22 (youngest entry); a load of addr 7 returns `d_mem` content via mem_readData.
- Four stores while cpu_re=1 every cycle → count=4; a fifth store gives stall=1 and count stays 4. Drop cpu_re → the fifth store is accepted in the same cycle as the drain, count stays 4, stall=0.
- Fill with addrs 0..3, wrap through 8 further stores with no loads → `d_mem`[0..3] hold the last-written values in order; pointers wrap; count returns to 0.
- Assert rst_n low while count=3 and mem_memWrite=1 → mem_memWrite falls without waiting for a clock edge; count=0; `d_mem` unchanged for the pending entries.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU memory stage and d_mem.
// Stores queue in a small FIFO and drain when no load holds the port; loads forward from the youngest match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic             cpu_we,
    input  logic             cpu_re,
    output logic [31:0]      cpu_rdata,
    output logic             stall,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_writeData,
    output logic             mem_memWrite,
    output logic             mem_memRead,
    input  logic [31:0]      mem_readData
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;

    logic        load;
    logic        drain;
    logic        push;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Store handshake: a store is presented with cpu_we=1 and is taken on the
    // next rising edge in any cycle where stall=0; while stall=1 the CPU must
    // hold cpu_we/cpu_addr/cpu_wdata stable and nothing is enqueued.
    always_comb begin
        load  = rst_n & cpu_re;
        drain = rst_n & ~cpu_re & (count_q != '0);
        push  = rst_n & cpu_we & ((count_q != FULL) | drain);
        stall = rst_n & cpu_we & (count_q == FULL) & ~drain;
    end

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == cpu_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        mem_address   = '0;
        mem_writeData = '0;
        mem_memWrite  = 1'b0;
        mem_memRead   = 1'b0;
        cpu_rdata     = '0;
        if (load) begin
            mem_memRead = 1'b1;
            mem_address = cpu_addr;
            cpu_rdata   = fwd_hit ? fwd_data : mem_readData;
        end else if (drain) begin
            mem_memWrite  = 1'b1;
            mem_address   = addr_q[head_q];
            mem_writeData = data_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            // When full, a push lands on the slot being drained; this write wins.
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            unique case ({push, drain})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= cpu_addr;
            data_q[tail_q] <= cpu_wdata;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle, plus directed literal checks.
// A 16-word d_mem model sits on the memory port.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cpu_we;
    logic             cpu_re;
    logic [31:0]      cpu_rdata;
    logic             stall;
    logic             empty;
    logic [PTR_W:0]   count;
    logic [31:0]      mem_address;
    logic [31:0]      mem_writeData;
    logic             mem_memWrite;
    logic             mem_memRead;
    wire  [31:0]      mem_readData;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .empty        (empty),
        .count        (count),
        .mem_address  (mem_address),
        .mem_writeData(mem_writeData),
        .mem_memWrite (mem_memWrite),
        .mem_memRead  (mem_memRead),
        .mem_readData (mem_readData)
    );

    // d_mem environment
    logic [31:0] dmem [16];
    assign mem_readData = mem_memRead ? dmem[mem_address[3:0]] : 'z;
    always @(posedge clk) if (mem_memWrite) dmem[mem_address[3:0]] <= mem_writeData;

    // Reference model: FIFO of {addr,data} plus the memory image it should produce
    logic [63:0] exp_q[$];
    logic [31:0] ref_mem [16];

    always @(posedge clk) begin
        if (rst_n) begin
            automatic bit          m_drain = !cpu_re && (exp_q.size() > 0);
            automatic bit          m_push  = cpu_we && ((exp_q.size() < DEPTH) || m_drain);
            automatic logic [63:0] e;
            if (m_drain) begin
                e = exp_q.pop_front();
                ref_mem[e[35:32]] = e[31:0];
            end
            if (m_push) exp_q.push_back({cpu_addr, cpu_wdata});
        end
    end

    always @(negedge rst_n) exp_q.delete();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        automatic bit          m_drain = rst_n && !cpu_re && (exp_q.size() > 0);
        automatic bit          m_load  = rst_n && cpu_re;
        automatic logic [31:0] e_addr  = 32'h0;
        automatic logic [31:0] e_wdata = 32'h0;
        automatic logic [31:0] e_rdata = 32'h0;
        automatic logic [63:0] e;
        if (m_load) begin
            e_addr  = cpu_addr;
            e_rdata = ref_mem[cpu_addr[3:0]];
            for (int i = 0; i < exp_q.size(); i++) begin
                e = exp_q[i];
                if (e[63:32] == cpu_addr) e_rdata = e[31:0];
            end
        end else if (m_drain) begin
            e       = exp_q[0];
            e_addr  = e[63:32];
            e_wdata = e[31:0];
        end
        check("m_count",     32'(count),         32'(exp_q.size()));
        check("m_empty",     32'(empty),         32'(exp_q.size() == 0));
        check("m_stall",     32'(stall),
              32'(rst_n && cpu_we && exp_q.size() == DEPTH && !m_drain));
        check("m_memWrite",  32'(mem_memWrite),  32'(m_drain));
        check("m_memRead",   32'(mem_memRead),   32'(m_load));
        check("m_address",   mem_address,        e_addr);
        check("m_writeData", mem_writeData,      e_wdata);
        check("m_rdata",     cpu_rdata,          e_rdata);
    end

    task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        while (!empty && n < 20) begin
            tick();
            n++;
        end
        check("drain_done", 32'(empty), 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = 32'hA000_0000 + 32'(i);
            ref_mem[i] = 32'hA000_0000 + 32'(i);
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'd5, 32'h0000_1234);

        // Reset with a store request pending
        tick();
        tick();
        check("rst_count",    32'(count),        32'h0);
        check("rst_empty",    32'(empty),        32'h1);
        check("rst_memWrite", 32'(mem_memWrite), 32'h0);
        check("rst_stall",    32'(stall),        32'h0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'd1, 32'h0000_1234);
        #1;
        check("first_stall", 32'(stall), 32'h0);
        tick();
        check("first_count", 32'(count), 32'h1);
        wait_empty();
        check("first_mem", dmem[1], 32'h0000_1234);

        // Single store then idle drain
        drive(1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
        tick();
        check("st_count", 32'(count), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("st_memWrite", 32'(mem_memWrite), 32'h1);
        check("st_address",  mem_address,       32'd5);
        check("st_wdata",    mem_writeData,     32'hDEAD_BEEF);
        tick();
        check("st_mem",   dmem[5],         32'hDEAD_BEEF);
        check("st_empty", 32'(empty),      32'h1);

        // Forwarding: youngest entry wins, misses come from d_mem
        drive(1'b1, 1'b1, 32'd3, 32'h11);
        #1;
        check("fw_miss3", cpu_rdata, 32'hA000_0003);
        tick();
        drive(1'b1, 1'b1, 32'd3, 32'h22);
        #1;
        check("fw_first", cpu_rdata, 32'h11);
        tick();
        drive(1'b0, 1'b1, 32'd3, 32'h0);
        #1;
        check("fw_young",    cpu_rdata,         32'h22);
        check("fw_noWrite",  32'(mem_memWrite), 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'd7, 32'h0);
        #1;
        check("fw_mem7", cpu_rdata, 32'hA000_0007);
        tick();
        wait_empty();
        check("fw_final3", dmem[3], 32'h22);

        // Fill while loads hold the port, then stall, then drain+push together
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'(12 + i), 32'hC0 + 32'(i));
            tick();
        end
        check("full_count", 32'(count), 32'h4);
        drive(1'b1, 1'b1, 32'd8, 32'hC8);
        #1;
        check("full_stall", 32'(stall), 32'h1);
        tick();
        check("full_hold", 32'(count), 32'h4);
        drive(1'b1, 1'b0, 32'd8, 32'hC8);
        #1;
        check("swap_stall", 32'(stall),       32'h0);
        check("swap_addr",  mem_address,      32'd12);
        tick();
        check("swap_count", 32'(count), 32'h4);
        wait_empty();
        for (int i = 0; i < 4; i++) check("full_mem", dmem[12 + i], 32'hC0 + 32'(i));
        check("full_mem8", dmem[8], 32'hC8);

        // Pointer wrap with back-to-back stores and no loads
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 32'(i % 4), 32'h100 + 32'(i));
            tick();
        end
        wait_empty();
        for (int a = 0; a < 4; a++) check("wrap_mem", dmem[a], 32'h108 + 32'(a));

        // Asynchronous reset while a drain is in progress
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'(9 + i), 32'h900 + 32'(i));
            tick();
        end
        check("ar_count", 32'(count), 32'h3);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("ar_memWrite", 32'(mem_memWrite), 32'h1);
        check("ar_addr",     mem_address,       32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_wr_drop", 32'(mem_memWrite), 32'h0);
        check("ar_count0",  32'(count),        32'h0);
        check("ar_empty",   32'(empty),        32'h1);
        tick();
        for (int i = 0; i < 3; i++) check("ar_mem", dmem[9 + i], 32'hA000_0009 + 32'(i));
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 16; i++) check("img", dmem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
